lexer: RTL and testbench

LEXER -- requirements
Module: lexer

---
 rtl/lexer.sv | 146 ++++++++++++++
 tb/tb_lexer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lexer.sv
// Character-stream lexer: turns ASCII arithmetic expressions into 16-bit
// {kind, value} tokens, one at a time, with a RECEIVE handshake to the parser.
module lexer #(
    parameter logic [7:0] EOF_CHAR = 8'h0A
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        C_VALID,
    input  logic [7:0]  C_DATA,
    output logic        C_READY,
    output logic        O_VALID,
    output logic [15:0] O_TOKEN,
    input  logic        RECEIVE,
    output logic [2:0]  STAT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NUM   = 3'd1,
        S_EMIT  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [7:0] KIND_EOF = 8'h00;
    localparam logic [7:0] KIND_NUM = 8'h01;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_blank(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h09) || (c == 8'h0D);
    endfunction

    // Returns 8'h00 for characters that are not operators or parentheses.
    function automatic logic [7:0] op_kind(input logic [7:0] c);
        logic [7:0] k;
        case (c)
            8'h2B:   k = 8'h02;
            8'h2D:   k = 8'h03;
            8'h2A:   k = 8'h04;
            8'h2F:   k = 8'h05;
            8'h28:   k = 8'h06;
            8'h29:   k = 8'h07;
            default: k = 8'h00;
        endcase
        return k;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  acc_q, acc_d;
    logic        eof_q, eof_d;
    logic [15:0] tok_q, tok_d;
    logic [11:0] acc_sum_s;
    logic        c_ready_s;

    // Next-state, accumulator and token-load logic.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        eof_d     = eof_q;
        tok_d     = tok_q;
        c_ready_s = 1'b0;
        acc_sum_s = ({4'h0, acc_q} * 12'd10) + {8'h00, C_DATA[3:0]};
        case (state_q)
            S_IDLE: begin
                c_ready_s = 1'b1;
                if (C_VALID) begin
                    if (is_blank(C_DATA)) begin
                        state_d = S_IDLE;
                    end else if (is_digit(C_DATA)) begin
                        acc_d   = {4'h0, C_DATA[3:0]};
                        state_d = S_NUM;
                    end else if (op_kind(C_DATA) != 8'h00) begin
                        tok_d   = {op_kind(C_DATA), 8'h00};
                        state_d = S_EMIT;
                    end else if (C_DATA == EOF_CHAR) begin
                        tok_d   = {KIND_EOF, 8'h00};
                        eof_d   = 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NUM: begin
                c_ready_s = is_digit(C_DATA);
                if (C_VALID && is_digit(C_DATA)) begin
                    if (acc_sum_s > 12'd255) begin
                        state_d = S_ERROR;
                    end else begin
                        acc_d = acc_sum_s[7:0];
                    end
                end else if (C_VALID) begin
                    // The terminator stays on C_DATA and is consumed later from S_IDLE.
                    tok_d   = {KIND_NUM, acc_q};
                    state_d = S_EMIT;
                end else begin
                    state_d = S_NUM;
                end
            end
            S_EMIT: begin
                if (RECEIVE) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_GAP: begin
                if (eof_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            acc_q   <= 8'h00;
            eof_q   <= 1'b0;
            tok_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            eof_q   <= eof_d;
            tok_q   <= tok_d;
        end
    end

    assign C_READY = c_ready_s;
    assign O_VALID = (state_q == S_EMIT);
    assign O_TOKEN = tok_q;
    assign STAT    = {state_q == S_IDLE, state_q == S_DONE, state_q == S_ERROR};

endmodule

// File: tb/tb_lexer.sv
// Randomised and directed bench for lexer, checked against a string-level tokenizer model.
module tb_lexer;

    logic        CLK;
    logic        RST;
    logic        C_VALID;
    logic [7:0]  C_DATA;
    logic        C_READY;
    logic        O_VALID;
    logic [15:0] O_TOKEN;
    logic        RECEIVE;
    logic [2:0]  STAT;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [2:0]  exp_stat;

    lexer #(.EOF_CHAR(8'h0A)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .C_VALID (C_VALID),
        .C_DATA  (C_DATA),
        .C_READY (C_READY),
        .O_VALID (O_VALID),
        .O_TOKEN (O_TOKEN),
        .RECEIVE (RECEIVE),
        .STAT    (STAT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] kind_of(input logic [7:0] c);
        logic [7:0] k;
        case (c)
            8'h2B:   k = 8'h02;
            8'h2D:   k = 8'h03;
            8'h2A:   k = 8'h04;
            8'h2F:   k = 8'h05;
            8'h28:   k = 8'h06;
            8'h29:   k = 8'h07;
            default: k = 8'h00;
        endcase
        return k;
    endfunction

    // Whole-string tokenizer: expected token list and final STAT.
    task automatic model(input string s);
        int         num;
        logic [7:0] c;
        logic [7:0] k;
        num = -1;
        exp_q.delete();
        exp_stat = 3'b100;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            k = kind_of(c);
            if (num >= 0) begin
                if (c >= 8'h30 && c <= 8'h39) begin
                    num = num * 10 + int'(c - 8'h30);
                    if (num > 255) begin
                        exp_stat = 3'b001;
                        return;
                    end
                    continue;
                end
                exp_q.push_back({8'h01, 8'(num)});
                num = -1;
            end
            if (c == 8'h20 || c == 8'h09 || c == 8'h0D) continue;
            if (c >= 8'h30 && c <= 8'h39) begin
                num = int'(c - 8'h30);
            end else if (k != 8'h00) begin
                exp_q.push_back({k, 8'h00});
            end else if (c == 8'h0A) begin
                exp_q.push_back(16'h0000);
                exp_stat = 3'b010;
                return;
            end else begin
                exp_stat = 3'b001;
                return;
            end
        end
        if (num >= 0) exp_stat = 3'b000;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST     = 1'b1;
        C_VALID = 1'b0;
        RECEIVE = 1'b0;
        #1;
        chk("rst_ovalid", 32'(O_VALID), 32'd0);
        chk("rst_token", 32'(O_TOKEN), 32'h0000);
        chk("rst_stat", 32'(STAT), 32'b100);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Feeds s with random stalls, acts as parser (rx_delay < 0: random delay).
    task automatic run_seq(input string s, input int rx_delay);
        int          idx = 0;
        int          quiet = 0;
        int          cyc = 0;
        int          wait_cnt = 0;
        bit          acc_pend = 0;
        bit          lat_pend = 0;
        bit          in_tok = 0;
        bit          rx_last = 0;
        logic [15:0] held = 16'h0000;
        model(s);
        do_reset();
        got_q.delete();
        while (quiet < 8 && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            if (acc_pend) idx++;
            if (lat_pend) chk("op_latency", 32'(O_VALID), 32'd1);
            if (rx_last) chk("gap_low", 32'(O_VALID), 32'd0);
            acc_pend = 0;
            lat_pend = 0;
            rx_last  = 0;
            RECEIVE  = 1'b0;
            if (O_VALID) begin
                chk("emit_rdy", 32'(C_READY), 32'd0);
                if (!in_tok) begin
                    in_tok   = 1;
                    held     = O_TOKEN;
                    wait_cnt = (rx_delay < 0) ? int'($urandom_range(0, 3)) : rx_delay;
                end else begin
                    chk("tok_stable", 32'(O_TOKEN), 32'(held));
                end
                if (wait_cnt == 0) begin
                    RECEIVE = 1'b1;
                    got_q.push_back(held);
                    in_tok  = 0;
                    rx_last = 1;
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                RECEIVE = 1'b1;
            end
            if (idx < s.len() && $urandom_range(0, 3) != 0) begin
                C_VALID = 1'b1;
                C_DATA  = s[idx];
            end else begin
                C_VALID = 1'b0;
                C_DATA  = 8'($urandom_range(0, 255));
            end
            #1;
            if (C_VALID && C_READY) begin
                acc_pend = 1;
                lat_pend = (kind_of(C_DATA) != 8'h00) || (C_DATA == 8'h0A);
            end
            if (!O_VALID && !acc_pend && (STAT[1] || STAT[0] || idx >= s.len())) quiet++;
            else quiet = 0;
        end
        C_VALID = 1'b0;
        RECEIVE = 1'b0;
        chk("timeout", 32'(cyc < 3000), 32'd1);
        chk("ntok", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("tok%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        chk("stat", 32'(STAT), 32'(exp_stat));
        if (exp_stat != 3'b100) begin
            C_VALID = 1'b1;
            C_DATA  = 8'h31;
            #1;
            chk("final_rdy", 32'(C_READY), 32'd0);
            C_VALID = 1'b0;
        end
    endtask

    function automatic string rand_expr();
        string      s = "";
        int         len;
        int         r;
        logic [7:0] c;
        string      ops = "+-*/()";
        string      ws = " \t\r";
        len = int'($urandom_range(1, 10));
        for (int i = 0; i < len; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      c = 8'h30 + 8'($urandom_range(0, 9));
            else if (r < 75) c = ops[int'($urandom_range(0, 5))];
            else if (r < 92) c = ws[int'($urandom_range(0, 2))];
            else if (r < 95) c = 8'h61;
            else             c = 8'h39;
            s = $sformatf("%s%c", s, c);
        end
        return {s, "\n"};
    endfunction

    initial begin
        RST     = 1'b1;
        C_VALID = 1'b0;
        C_DATA  = 8'h00;
        RECEIVE = 1'b0;

        run_seq("12+3\n", 2);
        chk("ex1_t0", 32'(got_q[0]), 32'h010C);
        chk("ex1_t1", 32'(got_q[1]), 32'h0200);
        chk("ex1_t2", 32'(got_q[2]), 32'h0103);
        chk("ex1_t3", 32'(got_q[3]), 32'h0000);
        chk("ex1_stat", 32'(STAT), 32'b010);

        run_seq("255*256", -1);
        chk("ovf_t0", 32'(got_q[0]), 32'h01FF);
        chk("ovf_t1", 32'(got_q[1]), 32'h0400);
        chk("ovf_stat", 32'(STAT), 32'b001);

        run_seq(" ( 7 ) \n", -1);
        chk("ws_n", 32'(got_q.size()), 32'd4);
        chk("ws_t1", 32'(got_q[1]), 32'h0107);

        run_seq("+\n", 10);

        // Number held across idle input, terminator consumed only after the gap.
        do_reset();
        C_VALID = 1'b1;
        C_DATA  = 8'h34;
        @(negedge CLK);
        C_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_ovalid", 32'(O_VALID), 32'd0);
            chk("hold_stat", 32'(STAT), 32'b000);
        end
        C_VALID = 1'b1;
        C_DATA  = 8'h0A;
        #1;
        chk("term_rdy", 32'(C_READY), 32'd0);
        @(negedge CLK);
        chk("num_valid", 32'(O_VALID), 32'd1);
        chk("num_tok", 32'(O_TOKEN), 32'h0104);
        RECEIVE = 1'b1;
        @(negedge CLK);
        RECEIVE = 1'b0;
        chk("gap_valid", 32'(O_VALID), 32'd0);
        chk("gap_rdy", 32'(C_READY), 32'd0);
        @(negedge CLK);
        chk("idle_rdy", 32'(C_READY), 32'd1);
        @(negedge CLK);
        C_VALID = 1'b0;
        chk("eof_valid", 32'(O_VALID), 32'd1);
        chk("eof_tok", 32'(O_TOKEN), 32'h0000);
        RECEIVE = 1'b1;
        @(negedge CLK);
        RECEIVE = 1'b0;
        @(negedge CLK);
        chk("done_stat", 32'(STAT), 32'b010);

        // Asynchronous reset while a token is presented.
        do_reset();
        C_VALID = 1'b1;
        C_DATA  = 8'h2B;
        @(negedge CLK);
        C_VALID = 1'b0;
        chk("pre_rst_valid", 32'(O_VALID), 32'd1);
        #3;
        RST = 1'b1;
        #1;
        chk("async_ovalid", 32'(O_VALID), 32'd0);
        chk("async_token", 32'(O_TOKEN), 32'h0000);
        chk("async_stat", 32'(STAT), 32'b100);
        @(negedge CLK);
        RST = 1'b0;
        run_seq("9\n", -1);
        chk("post_rst_t0", 32'(got_q[0]), 32'h0109);
        chk("post_rst_t1", 32'(got_q[1]), 32'h0000);

        for (int n = 0; n < 40; n++) run_seq(rand_expr(), -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
